// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: samples a VGA HS/VS/BLANK_N/RGB stream and recovers
// pixel coordinates, frame markers and geometry lock status.
module vga_sync_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    input  logic        i_vga_hs,
    input  logic        i_vga_vs,
    input  logic        i_vga_blank_n,
    input  logic [7:0]  i_vga_r,
    input  logic [7:0]  i_vga_g,
    input  logic [7:0]  i_vga_b,
    output logic        o_valid,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic [23:0] o_rgb,
    output logic        o_frame_start,
    output logic        o_frame_end,
    output logic        o_locked,
    output logic        o_err
);
    localparam logic [10:0] HA = 11'(H_ACTIVE);
    localparam logic [10:0] VA = 11'(V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, WAIT, TRACK, LOCKED} state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic        r_en;
    logic        r_hs_act;
    logic        r_vs_act;
    logic        r_blank_n;
    logic [23:0] r_rgb;
    logic        r_vs_prev;
    logic        r_blank_prev;
    logic        r_armed;
    logic [10:0] r_x;
    logic [10:0] r_y;

    logic        w_vs_rise;
    logic        w_b_rise;
    logic        w_b_fall;
    logic [10:0] w_px;
    logic [10:0] w_lines;
    logic        w_chk;
    logic        w_viol;
    logic        w_armed_n;
    logic        w_valid;
    logic        w_fend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en      <= 1'b0;
            r_hs_act  <= 1'b0;
            r_vs_act  <= 1'b0;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_en <= i_pix_en;
            if (i_pix_en) begin
                r_hs_act  <= (i_vga_hs == SYNC_POL);
                r_vs_act  <= (i_vga_vs == SYNC_POL);
                r_blank_n <= i_vga_blank_n;
                r_rgb     <= {i_vga_r, i_vga_g, i_vga_b};
            end
        end
    end

    always_comb begin
        w_vs_rise = r_vs_act & ~r_vs_prev;
        w_b_rise  = r_blank_n & ~r_blank_prev;
        w_b_fall  = ~r_blank_n & r_blank_prev;
        w_px      = w_b_rise ? 11'd0 : r_x;
        // a line ending on the same sample as vs_rise still counts
        w_lines   = r_y + {10'd0, w_b_fall};
        w_chk     = (r_state == TRACK) || (r_state == LOCKED);
        w_viol    = w_chk & ((w_b_fall & (r_x != HA))
                  | (w_b_rise & ~w_vs_rise & (r_y >= VA))
                  | (r_hs_act & r_blank_n)
                  | (w_vs_rise & (w_lines != VA)));
        w_state_n = r_state;
        w_armed_n = r_armed;
        unique case (r_state)
            SEARCH: begin
                if (w_vs_rise) begin
                    w_state_n = WAIT;
                    w_armed_n = 1'b1;
                end
            end
            WAIT: begin
                if (w_vs_rise) w_armed_n = 1'b1;
                if (r_armed & w_b_rise & ~r_vs_act) w_state_n = TRACK;
            end
            TRACK, LOCKED: begin
                if (w_viol) begin
                    w_state_n = WAIT;
                    w_armed_n = w_vs_rise;
                end else if (w_vs_rise) begin
                    w_state_n = LOCKED;
                end
            end
            default: w_state_n = SEARCH;
        endcase
        w_valid = (r_state == LOCKED) & r_blank_n & ~w_viol
                & (w_px < HA) & (r_y < VA);
        w_fend  = (r_state == LOCKED) & w_b_fall & ~w_viol
                & (r_y == VA - 11'd1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= SEARCH;
            r_armed       <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_blank_prev  <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            o_valid       <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_rgb         <= '0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_err         <= 1'b0;
            if (r_en) begin
                r_state      <= w_state_n;
                r_armed      <= w_armed_n;
                r_vs_prev    <= r_vs_act;
                r_blank_prev <= r_blank_n;
                // saturates at HA+1 so runaway lines still fail the check
                if (r_blank_n && (w_px <= HA)) r_x <= w_px + 11'd1;
                if (w_vs_rise) r_y <= '0;
                else if (w_b_fall && (r_y != '1)) r_y <= r_y + 11'd1;
                o_valid       <= w_valid;
                o_frame_start <= w_valid & (w_px == 11'd0) & (r_y == 11'd0);
                o_frame_end   <= w_fend;
                o_err         <= w_viol;
                o_locked      <= (w_state_n == LOCKED);
                if (w_valid) begin
                    o_x   <= w_px;
                    o_y   <= r_y;
                    o_rgb <= r_rgb;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 8x4 raster
// (12 clocks per line: 8 active, 1 front, 2 sync, 1 back; 7+ lines per frame).
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    localparam int HA = 8;
    localparam int VA = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        blank_n = 1'b0;
    logic [7:0]  r = '0;
    logic [7:0]  g = '0;
    logic [7:0]  b = '0;
    logic        o_valid;
    logic [10:0] o_x;
    logic [10:0] o_y;
    logic [23:0] o_rgb;
    logic        o_frame_start;
    logic        o_frame_end;
    logic        o_locked;
    logic        o_err;

    vga_sync_decoder #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .SYNC_POL(1'b0)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_pix_en(pix_en),
        .i_vga_hs(hs),
        .i_vga_vs(vs),
        .i_vga_blank_n(blank_n),
        .i_vga_r(r),
        .i_vga_g(g),
        .i_vga_b(b),
        .o_valid(o_valid),
        .o_x(o_x),
        .o_y(o_y),
        .o_rgb(o_rgb),
        .o_frame_start(o_frame_start),
        .o_frame_end(o_frame_end),
        .o_locked(o_locked),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        act;
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] rgb;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   n_valid, n_fs, n_fe, n_err;
    bit   tog = 1'b0;
    exp_t d1 = '0;
    exp_t d2 = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] col(input int x, input int y);
        if (x == HA - 1 && y == VA - 1) return 24'h123456;
        return {8'(x * 17), 8'(y * 29), 8'h5A};
    endfunction

    // check what the sample of two clocks ago produced, then drive
    task automatic step(input logic en, input logic h, input logic v,
                        input logic bl, input int x, input int y);
        logic [23:0] c;
        @(negedge clk);
        if (o_valid) begin
            n_valid++;
            chk("pixel", {1'b1, o_x, o_y, o_rgb}, d2);
        end
        if (o_frame_start) begin
            n_fs++;
            chk("fs_xy", {o_valid, o_x, o_y}, {1'b1, 11'd0, 11'd0});
        end
        if (o_frame_end) begin
            n_fe++;
            chk("fe_xy", {o_x, o_y}, {11'(HA - 1), 11'(VA - 1)});
        end
        if (o_err) begin
            n_err++;
            chk("err_unlock", o_locked, 1'b0);
        end
        c = col(x, y);
        pix_en = en;
        hs = h;
        vs = v;
        blank_n = bl;
        {r, g, b} = c;
        d2 = d1;
        d1 = '{en & bl, 11'(x), 11'(y), c};
    endtask

    task automatic line(input logic vsync, input int nact, input int y);
        for (int i = 0; i < 12; i++) begin
            logic bl;
            logic h;
            bl = (i < nact);
            h = !(i == 9 || i == 10);
            step(1'b1, h, !vsync, bl, i, y);
            if (tog) step(1'b0, h, !vsync, bl, i, y);
        end
    endtask

    task automatic do_reset();
        chk("locked_pre_rst", o_locked, 1'b1);
        @(negedge clk);
        pix_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs",
            {o_valid, o_x, o_y, o_rgb, o_frame_start, o_frame_end,
             o_locked, o_err}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame(input int nrows, input int short_row,
                         input int rst_row);
        n_valid = 0;
        n_fs = 0;
        n_fe = 0;
        n_err = 0;
        line(1'b1, 0, 0);
        line(1'b0, 0, 0);
        for (int row = 0; row < nrows; row++) begin
            if (row == rst_row) do_reset();
            line(1'b0, (row == short_row) ? HA - 1 : HA, row);
        end
        line(1'b0, 0, 0);
    endtask

    initial begin
        #12;
        chk("rst_outs",
            {o_valid, o_x, o_y, o_rgb, o_frame_start, o_frame_end,
             o_locked, o_err}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        frame(VA, -1, -1);
        chk("A_valid", n_valid, 0);
        chk("A_err", n_err, 0);
        chk("A_locked", o_locked, 1'b0);

        frame(VA, -1, -1);
        chk("B_valid", n_valid, 32);
        chk("B_fs", n_fs, 1);
        chk("B_fe", n_fe, 1);
        chk("B_err", n_err, 0);
        chk("B_locked", o_locked, 1'b1);
        chk("B_last_rgb", o_rgb, 24'h123456);

        frame(VA, -1, -1);
        chk("C_valid", n_valid, 32);
        chk("C_fe", n_fe, 1);

        frame(VA, 1, -1);
        chk("D_valid", n_valid, 15);
        chk("D_err", n_err, 1);
        chk("D_fe", n_fe, 0);
        chk("D_locked", o_locked, 1'b0);

        frame(VA, -1, -1);
        chk("E_valid", n_valid, 0);
        chk("E_err", n_err, 0);
        chk("E_locked", o_locked, 1'b0);

        frame(VA, -1, -1);
        chk("F_valid", n_valid, 32);
        chk("F_locked", o_locked, 1'b1);

        frame(VA + 1, -1, -1);
        chk("G_valid", n_valid, 32);
        chk("G_fe", n_fe, 1);
        chk("G_err", n_err, 1);
        chk("G_locked", o_locked, 1'b0);

        frame(VA, -1, -1);
        chk("H_valid", n_valid, 0);

        tog = 1'b1;
        frame(VA, -1, -1);
        tog = 1'b0;
        chk("I_valid", n_valid, 32);
        chk("I_fs", n_fs, 1);
        chk("I_fe", n_fe, 1);
        chk("I_err", n_err, 0);
        chk("I_locked", o_locked, 1'b1);

        frame(VA, -1, 2);
        chk("J_valid", n_valid, 16);
        chk("J_err", n_err, 0);
        chk("J_locked", o_locked, 1'b0);

        frame(VA, -1, -1);
        chk("K_valid", n_valid, 0);
        chk("K_locked", o_locked, 1'b0);

        frame(VA, -1, -1);
        chk("L_valid", n_valid, 32);
        chk("L_err", n_err, 0);
        chk("L_locked", o_locked, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
